// File: rtl/drip_pkg.sv
// Shared definitions for the drip zone counter.
//   bcd_digit_t  - one BCD decade (0..9)
//   BCD_MAX      - largest legal decade value
//   SYNC_STAGES  - depth of the pulse synchroniser
//   clamp_digit  - saturates a limit digit to 9
//   bcd_step     - next value of a decade given its carry-in
package drip_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX     = 4'd9;
    localparam int         SYNC_STAGES = 2;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic bcd_digit_t bcd_step(input bcd_digit_t d, input logic cin);
        if (!cin) return d;
        return (d >= BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/drip_bcd_digit.sv
// One BCD decade of a drip counter.
//   clk, reset_n - clock, async active-low reset
//   inc          - channel-wide increment request
//   carry_in     - all lower decades are at 9 (tie high for decade 0)
//   clear        - synchronous load of zero, overrides inc
//   value        - current decade value
//   carry_out    - carry_in and this decade at 9
module drip_bcd_digit
    import drip_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       carry_in,
    input  logic       clear,
    output bcd_digit_t value,
    output logic       carry_out
);

    assign carry_out = carry_in && (value == BCD_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (inc)
            value <= bcd_step(value, carry_in);
    end

endmodule

// File: rtl/drip_zone_counter.sv
// Multi-channel BCD drip counter with shared limit and enable.
//   clk, reset_n - clock, async active-low reset
//   pulse        - raw per-channel drip sensor inputs (asynchronous)
//   clear        - per-channel synchronous clear of count/done/overflow
//   enable       - global count enable; edges seen while low are dropped
//   limit        - shared BCD terminal count (0 = unlimited)
//   count        - per-channel BCD count, channel 0 in the low bits
//   done         - per-channel sticky limit-reached flag
//   overflow     - per-channel one-cycle wrap / discarded-edge strobe
module drip_zone_counter
    import drip_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIGITS   = 2,
    parameter int WRAP     = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS-1:0]          pulse,
    input  logic [CHANNELS-1:0]          clear,
    input  logic                         enable,
    input  logic [DIGITS*4-1:0]          limit,
    output logic [CHANNELS*DIGITS*4-1:0] count,
    output logic [CHANNELS-1:0]          done,
    output logic [CHANNELS-1:0]          overflow
);

    localparam int CW = DIGITS * 4;

    logic [CW-1:0] lim;
    logic          lim_zero;

    for (genvar d = 0; d < DIGITS; d++) begin : g_lim
        assign lim[d*4 +: 4] = clamp_digit(limit[d*4 +: 4]);
    end
    assign lim_zero = (lim == '0);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   edge_q;
        logic [CW-1:0]          cur;
        logic [CW-1:0]          nxt;
        logic [DIGITS:0]        carry;
        logic                   take;
        logic                   hit;
        logic                   past;
        logic                   inc_en;
        logic                   load_zero;
        logic                   set_done;
        logic                   ovf_nxt;
        logic                   done_q;
        logic                   ovf_q;

        // Edge strobe is registered so a pulse sampled at edge N counts at N+3.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
                edge_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pulse[ch]};
                prev_q <= sync_q[SYNC_STAGES-1];
                edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            end
        end

        assign carry[0] = 1'b1;

        for (genvar d = 0; d < DIGITS; d++) begin : g_dig
            drip_bcd_digit u_digit (
                .clk       (clk),
                .reset_n   (reset_n),
                .inc       (inc_en),
                .carry_in  (carry[d]),
                .clear     (clear[ch] | load_zero),
                .value     (cur[d*4 +: 4]),
                .carry_out (carry[d+1])
            );
            assign nxt[d*4 +: 4] = bcd_step(cur[d*4 +: 4], carry[d]);
        end

        assign take = edge_q & enable & ~clear[ch];
        assign hit  = (nxt == lim);
        // Covers a limit lowered below the running count as well as saturation.
        assign past = (cur >= lim);

        always_comb begin
            inc_en    = 1'b0;
            load_zero = 1'b0;
            set_done  = 1'b0;
            ovf_nxt   = 1'b0;
            if (take) begin
                if (lim_zero) begin
                    inc_en  = 1'b1;
                    ovf_nxt = carry[DIGITS];
                end else if ((WRAP != 0) && (hit || past)) begin
                    load_zero = 1'b1;
                    set_done  = 1'b1;
                    ovf_nxt   = 1'b1;
                end else if (past) begin
                    set_done = 1'b1;
                    ovf_nxt  = 1'b1;
                end else begin
                    inc_en   = 1'b1;
                    set_done = hit;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (clear[ch]) begin
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                done_q <= done_q | set_done;
                ovf_q  <= ovf_nxt;
            end
        end

        assign count[ch*CW +: CW] = cur;
        assign done[ch]           = done_q;
        assign overflow[ch]       = ovf_q;
    end

endmodule

// File: tb/tb_drip_zone_counter.sv
module tb_drip_zone_counter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  pulse;
    logic [3:0]  clear;
    logic        enable;
    logic [7:0]  limit;
    logic [31:0] count_a, count_b;
    logic [3:0]  done_a, done_b;
    logic [3:0]  ovf_a, ovf_b;

    int tests  = 0;
    int errors = 0;
    int ovf_cnt_a [4] = '{default: 0};
    int ovf_cnt_b [4] = '{default: 0};
    int base_a, base_b;

    always #5 clk = ~clk;

    drip_zone_counter #(.CHANNELS(4), .DIGITS(2), .WRAP(0)) dut (
        .clk(clk), .reset_n(reset_n), .pulse(pulse), .clear(clear),
        .enable(enable), .limit(limit), .count(count_a),
        .done(done_a), .overflow(ovf_a)
    );

    drip_zone_counter #(.CHANNELS(4), .DIGITS(2), .WRAP(1)) dut_w (
        .clk(clk), .reset_n(reset_n), .pulse(pulse), .clear(clear),
        .enable(enable), .limit(limit), .count(count_b),
        .done(done_b), .overflow(ovf_b)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ovf_a[i]) ovf_cnt_a[i] = ovf_cnt_a[i] + 1;
            if (ovf_b[i]) ovf_cnt_b[i] = ovf_cnt_b[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drip(input logic [3:0] mask);
        pulse = pulse | mask;
        repeat (3) tick();
        pulse = pulse & ~mask;
        repeat (3) tick();
    endtask

    function automatic logic [7:0] ch_cnt(input logic [31:0] v, input int ch);
        return v[ch*8 +: 8];
    endfunction

    initial begin
        reset_n = 1'b0;
        pulse   = '0;
        clear   = '0;
        enable  = 1'b1;
        limit   = 8'h10;
        repeat (3) tick();
        check("reset_count", count_a, 32'h0);
        check("reset_done", {28'h0, done_a}, 32'h0);
        check("reset_ovf", {28'h0, ovf_a}, 32'h0);
        check("reset_count_w", count_b, 32'h0);
        reset_n = 1'b1;
        tick();

        // Latency: first sampled at next edge, counted three edges later
        pulse[3] = 1'b1;
        repeat (3) tick();
        check("latency_before", ch_cnt(count_a, 3), 8'h00);
        tick();
        check("latency_after", ch_cnt(count_a, 3), 8'h01);
        pulse[3] = 1'b0;
        repeat (3) tick();

        // Saturating at 10 (dut) and wrapping at 10 (dut_w) on ch0
        base_a = ovf_cnt_a[0];
        base_b = ovf_cnt_b[0];
        for (int i = 1; i <= 12; i++) begin
            drip(4'b0001);
            check($sformatf("sat_cnt_%0d", i), ch_cnt(count_a, 0),
                  (i < 10) ? 8'(i) : 8'h10);
            check($sformatf("sat_done_%0d", i), {31'h0, done_a[0]},
                  (i >= 10) ? 32'h1 : 32'h0);
        end
        check("sat_ovf", ovf_cnt_a[0] - base_a, 2);
        check("wrap10_cnt", ch_cnt(count_b, 0), 8'h02);
        check("wrap10_done", {31'h0, done_b[0]}, 32'h1);
        check("wrap10_ovf", ovf_cnt_b[0] - base_b, 1);

        // Clear in the exact cycle the detected edge is applied
        pulse[0] = 1'b1;
        repeat (3) tick();
        clear[0] = 1'b1;
        tick();
        clear[0] = 1'b0;
        check("clr_cnt", ch_cnt(count_a, 0), 8'h00);
        check("clr_done", {31'h0, done_a[0]}, 32'h0);
        pulse[0] = 1'b0;
        repeat (4) tick();
        check("clr_no_inc", ch_cnt(count_a, 0), 8'h00);
        check("clr_no_inc_w", ch_cnt(count_b, 0), 8'h00);
        drip(4'b0001);
        check("clr_next", ch_cnt(count_a, 0), 8'h01);

        // Limit 05 on ch1: dut_w wraps at 5th edge, dut saturates
        limit  = 8'h05;
        base_a = ovf_cnt_a[1];
        base_b = ovf_cnt_b[1];
        for (int i = 1; i <= 7; i++) begin
            drip(4'b0010);
            if (i == 5) begin
                check("w5_cnt", ch_cnt(count_b, 1), 8'h00);
                check("w5_done", {31'h0, done_b[1]}, 32'h1);
                check("w5_ovf", ovf_cnt_b[1] - base_b, 1);
            end
        end
        check("w5_final", ch_cnt(count_b, 1), 8'h02);
        check("s5_final", ch_cnt(count_a, 1), 8'h05);
        check("s5_ovf", ovf_cnt_a[1] - base_a, 2);

        // Unlimited: 101 pulses on ch2 rolls 99 -> 00 -> 01
        limit  = 8'h00;
        base_a = ovf_cnt_a[2];
        for (int i = 1; i <= 101; i++) begin
            drip(4'b0100);
            if (i == 99)  check("u99", ch_cnt(count_a, 2), 8'h99);
            if (i == 100) begin
                check("u100", ch_cnt(count_a, 2), 8'h00);
                check("u100_ovf", ovf_cnt_a[2] - base_a, 1);
            end
        end
        check("u101", ch_cnt(count_a, 2), 8'h01);
        check("u101_w", ch_cnt(count_b, 2), 8'h01);
        check("u_done", {31'h0, done_a[2]}, 32'h0);
        check("sticky_done", {31'h0, done_a[1]}, 32'h1);

        // Limit lowered below a running count
        for (int i = 0; i < 5; i++) drip(4'b0100);
        limit  = 8'h04;
        base_a = ovf_cnt_a[2];
        drip(4'b0100);
        check("low_cnt", ch_cnt(count_a, 2), 8'h06);
        check("low_done", {31'h0, done_a[2]}, 32'h1);
        check("low_ovf", ovf_cnt_a[2] - base_a, 1);
        check("low_cnt_w", ch_cnt(count_b, 2), 8'h00);
        check("low_done_w", {31'h0, done_b[2]}, 32'h1);

        // Enable low discards edges; re-enable with pulse held high
        enable = 1'b0;
        for (int i = 0; i < 3; i++) drip(4'b0001);
        check("dis_cnt", ch_cnt(count_a, 0), 8'h01);
        pulse[0] = 1'b1;
        repeat (5) tick();
        enable = 1'b1;
        repeat (5) tick();
        pulse[0] = 1'b0;
        repeat (3) tick();
        check("reen_cnt", ch_cnt(count_a, 0), 8'h01);
        check("reen_cnt_w", ch_cnt(count_b, 0), 8'h01);

        // Asynchronous reset with pulses in flight on all channels
        pulse = 4'hF;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check("arst_cnt", count_a, 32'h0);
        check("arst_cnt_w", count_b, 32'h0);
        check("arst_done", {28'h0, done_a, done_b}, 32'h0);
        check("arst_ovf", {28'h0, ovf_a, ovf_b}, 32'h0);
        pulse = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("post_rst_cnt", count_a, 32'h0);

        // Pulse already high when reset releases counts once
        pulse[0] = 1'b1;
        reset_n  = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("rel_high_cnt", count_a, 32'h0000_0001);
        check("rel_high_cnt_w", count_b, 32'h0000_0001);
        pulse[0] = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
